dm_store_ctrl: RTL
==================

Name: dm_store_ctrl

Overview:
Data-memory access controller between the MEM stage and a single-port word-wide data bus with a req/ack handshake. Stores go into a small posted-write buffer: sw/sh/sb/swl/swr each get byte-enable and lane alignment, then drain to the bus one per handshake. Loads are serialised behind pending stores. The pipeline is stalled while a request cannot be accepted or a load is outstanding.

Parameters:
DEPTH, 2, store-buffer entries; power of two, >=2.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  MEM stage has a memory access this cycle
cpu_we  in  1  1=store, 0=load
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, register-aligned (LSB = byte 0)
cpu_be_ctrl  in  3  0=sw 1=sh 2=sb 3=swl 4=swr; other values treated as sw
cpu_stall  out  1  freeze pipeline (combinational)
cpu_rdata  out  32  load word, raw (extension done downstream)
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
bus_req  out  1  bus request
bus_we  out  1  bus write
bus_addr  out  32  word address (bits [1:0] = 0)
bus_be  out  4  byte enables
bus_wdata  out  32  lane-aligned write data
bus_ack  in  1  transfer completes on the edge where bus_req & bus_ack
bus_rdata  in  32  read data, valid with bus_ack

Behaviour:
- Reset (async, reset_n=0): buffer emptied, FSM=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, cpu_rdata=0, cpu_rvalid=0. cpu_stall=0 while in reset. Asserting reset mid-transfer drops bus_req immediately and discards all buffered stores.
- BE by type (a=addr[1:0]): sb 0001<<a; sh a[1]=0 -> 0011, a[1]=1 -> 1100; swl a=0..3 -> 0001,0011,0111,1111; swr a=0..3 -> 1111,1110,1100,1000; sw/other 1111.
- Data alignment: sb = byte replicated x4; sh = halfword replicated x2; sw as is; swl = wdata >> 8*(3-a); swr = wdata << 8*a.
- Enqueue: cpu_req & cpu_we & !full -> entry {addr[31:2],be,data} written at edge, cpu_stall=0. If full -> cpu_stall=1 and no enqueue. full uses the registered count, so a dequeue in the same cycle does not free a slot for that cycle's request.
- FSM states IDLE, WR, RD.
  - IDLE: buffer non-empty -> WR. Else if cpu_req & !cpu_we -> RD, latching the word address.
  - WR: bus_req=1, bus_we=1; bus_addr, bus_be, bus_wdata from the head entry, held stable until ack. On ack: pop the head. If still non-empty, stay WR with the next head, back-to-back with no idle cycle. Otherwise -> IDLE.
  - RD: bus_req=1, bus_we=0, bus_be=1111. On ack: cpu_rdata<=bus_rdata, cpu_rvalid=1 next cycle, -> IDLE.
- Load stall: cpu_stall=1 from a load's first cycle until the cycle cpu_rvalid=1, inclusive of the drain of all older stores. The stall drops in the rvalid cycle. Minimum load latency with an empty buffer is 2 cycles plus bus wait.
- Ordering: stores drain FIFO in program order. A load never passes a buffered store unless the optional feature is enabled.
- bus_ack while bus_req=0 is ignored. Count never wraps past DEPTH or below 0.

Optional Feature:
LOAD_BYPASS_EN.
- Defined: in IDLE or between stores, a load whose word address matches no buffered entry goes to RD ahead of the pending stores. A load that matches any entry waits for the drain as normal.
- Undefined: loads always wait for an empty buffer.

Test Plan:
- Reset mid-WR (bus_ack held 0, reset_n pulsed low) -> bus_req=0 immediately; after release, buffer empty and no further bus write.
- sb to 0x103, data 0x000000AB -> bus_addr 0x100, bus_be 1000, bus_wdata 0xABABABAB, no stall.
- swl at a=1 with 0x11223344 -> be 0011, wdata 0x00001122; swr at a=2 -> be 1100, wdata 0x33440000.
- DEPTH=2, three back-to-back stores, bus_ack delayed 3 cycles -> third store stalls until the first ack. Bus writes occur in order with no idle cycle between them.
- Store to 0x200 then load 0x200, bus_rdata 0xDEADBEEF -> bus write precedes read; cpu_rvalid pulses once with 0xDEADBEEF; stall drops on the same cycle.
- LOAD_BYPASS_EN: store 0x300 pending with ack held off, load 0x400 -> RD issued next after the current write completes, ahead of the queued stores. Load 0x300 -> waits for the drain.

Source files
------------

// File: rtl/dm_store_ctrl_if.sv
// Bundles the MEM-stage request/response signals and the word-wide data bus used by dm_store_ctrl.
// slave is the controller's view; master is the view of the pipeline plus the bus target around it.
interface dm_store_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_be_ctrl;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be_ctrl, bus_ack, bus_rdata,
        output cpu_stall, cpu_rdata, cpu_rvalid, bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be_ctrl, bus_ack, bus_rdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid, bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/dm_store_ctrl.sv
// Data-memory controller: posted store buffer with byte-lane alignment, draining to a req/ack bus; loads wait behind stores.
// Optional macro LOAD_BYPASS_EN lets a load whose word address hits no buffered store go ahead of the buffer.
//
// state | meaning
// IDLE  | bus quiet; pick store drain or load
// WR    | writing the buffer head, pops on ack
// RD    | single word read, result registered on ack
module dm_store_ctrl #(
    parameter int DEPTH = 2
) (
    input logic           clk,
    input logic           reset_n,
    dm_store_ctrl_if.slave dm
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t          state_q, state_d;
    logic [29:0]     ent_addr_q [DEPTH];
    logic [3:0]      ent_be_q   [DEPTH];
    logic [31:0]     ent_data_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [29:0]     rd_addr_q, rd_addr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;

    logic            full, empty, push, pop;
    logic            load_req, bypass_ok;
    logic [1:0]      lane;
    logic [3:0]      st_be;
    logic [31:0]     st_data;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign lane  = dm.cpu_addr[1:0];
    assign push  = dm.cpu_req & dm.cpu_we & ~full;
    // The load held in MEM during its rvalid cycle is already served, so it must not restart.
    assign load_req = dm.cpu_req & ~dm.cpu_we & ~rvalid_q;

    always_comb begin
        st_be   = 4'b1111;
        st_data = dm.cpu_wdata;
        case (dm.cpu_be_ctrl)
            3'd1: begin
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{dm.cpu_wdata[15:0]}};
            end
            3'd2: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{dm.cpu_wdata[7:0]}};
            end
            3'd3: begin
                st_be   = 4'b1111 >> (2'd3 - lane);
                st_data = dm.cpu_wdata >> {(2'd3 - lane), 3'b000};
            end
            3'd4: begin
                st_be   = 4'b1111 << lane;
                st_data = dm.cpu_wdata << {lane, 3'b000};
            end
            default: ;
        endcase
    end

`ifdef LOAD_BYPASS_EN
    logic addr_hit;

    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - rd_ptr_q} < count_q) &&
                (ent_addr_q[i] == dm.cpu_addr[31:2]))
                addr_hit = 1'b1;
        end
    end

    assign bypass_ok = load_req & ~addr_hit;
`else
    assign bypass_ok = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        pop          = 1'b0;
        dm.bus_req   = 1'b0;
        dm.bus_we    = 1'b0;
        dm.bus_addr  = '0;
        dm.bus_be    = '0;
        dm.bus_wdata = '0;
        case (state_q)
            IDLE: begin
                if (load_req && (empty || bypass_ok)) begin
                    state_d   = RD;
                    rd_addr_d = dm.cpu_addr[31:2];
                end else if (!empty) begin
                    state_d = WR;
                end
            end
            WR: begin
                dm.bus_req   = 1'b1;
                dm.bus_we    = 1'b1;
                dm.bus_addr  = {ent_addr_q[rd_ptr_q], 2'b00};
                dm.bus_be    = ent_be_q[rd_ptr_q];
                dm.bus_wdata = ent_data_q[rd_ptr_q];
                if (dm.bus_ack) begin
                    pop = 1'b1;
                    if (bypass_ok) begin
                        state_d   = RD;
                        rd_addr_d = dm.cpu_addr[31:2];
                    end else if ((count_q > CW'(1)) || push) begin
                        state_d = WR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RD: begin
                dm.bus_req  = 1'b1;
                dm.bus_addr = {rd_addr_q, 2'b00};
                dm.bus_be   = 4'b1111;
                if (dm.bus_ack) begin
                    rdata_d  = dm.bus_rdata;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)
            wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= dm.cpu_addr[31:2];
            ent_be_q[wr_ptr_q]   <= st_be;
            ent_data_q[wr_ptr_q] <= st_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Stall is forced low in reset so the pipeline is never frozen by a stale request.
    assign dm.cpu_stall  = reset_n & ((dm.cpu_req & dm.cpu_we & full) | load_req);
    assign dm.cpu_rdata  = rdata_q;
    assign dm.cpu_rvalid = rvalid_q;

endmodule
